// File: rtl/pu_mux_if.sv
// pu_mux_if: bus-side load/selector/OE signals and OR-able result outputs of the mux PU.
interface pu_mux_if #(parameter int W = 32, parameter int WA = 4);
  logic signal_load;
  logic signal_sel;
  logic [1:0] signal_mode;
  logic [W-1:0] data_in;
  logic [WA-1:0] attr_in;
  logic signal_oe;
  logic [W-1:0] data_out;
  logic [WA-1:0] attr_out;
  modport master (
    output signal_load, signal_sel, signal_mode, data_in, attr_in, signal_oe,
    input data_out, attr_out
  );
  modport slave (
    input signal_load, signal_sel, signal_mode, data_in, attr_in, signal_oe,
    output data_out, attr_out
  );
endinterface

// File: rtl/pu_mux_unit.sv
// pu_mux_unit: N-slot bus multiplexer PU; drives the selected slot when OE, zero otherwise.
module pu_mux_unit #(
  parameter int W = 32,
  parameter int WA = 4,
  parameter int N = 4,
  parameter int SW = $clog2(N)
) (
  input logic clk,
  input logic rst,
  pu_mux_if.slave bus
);
  logic [W-1:0] slot_data [N];
  logic [WA-1:0] slot_attr [N];
  logic [SW:0] wp;
  logic [SW:0] wp_inc;
  logic [SW:0] wp_next;
  logic [SW-1:0] idx;
  logic [1:0] md;
  logic [W-1:0] sel_data;
  logic [WA-1:0] sel_attr;
  logic slot_load;
  logic idx_load;
  always_comb begin
    slot_load = bus.signal_load && !bus.signal_sel;
    idx_load = bus.signal_load && bus.signal_sel;
    wp_inc = wp + 1'b1;
    // wp never exceeds N-1, so its top bit after increment flags the wrap
    wp_next = bus.signal_oe ? '0 : slot_load ? (wp_inc[SW] ? '0 : wp_inc) : wp;
    sel_data = bus.signal_oe && md[1] ? slot_data[idx] : '0;
    sel_attr = bus.signal_oe && md[0] ? slot_attr[idx] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      idx <= '0;
      md <= '0;
      bus.data_out <= '0;
      bus.attr_out <= '0;
      for (int i = 0; i < N; i++) begin
        slot_data[i] <= '0;
        slot_attr[i] <= '0;
      end
    end else begin
      wp <= wp_next;
      bus.data_out <= sel_data;
      bus.attr_out <= sel_attr;
      if (idx_load) begin
        idx <= bus.data_in[W-2 -: SW];
        md <= bus.signal_mode;
      end
      if (slot_load) begin
        slot_data[wp[SW-1:0]] <= bus.data_in;
        slot_attr[wp[SW-1:0]] <= bus.attr_in;
      end
    end
  end
endmodule

// File: tb/tb_pu_mux_unit.sv
// tb_pu_mux_unit: table-driven cycle vectors with a one-cycle-latency expectation queue.
module tb_pu_mux_unit;
  logic clk = 1'b0;
  logic rst;
  pu_mux_if #(.W(32), .WA(4)) bus ();
  pu_mux_unit #(.W(32), .WA(4), .N(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic r;
    logic ld;
    logic sl;
    logic [1:0] md;
    logic [31:0] d;
    logic [3:0] a;
    logic oe;
    logic [31:0] ed;
    logic [3:0] ea;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    logic [3:0] a;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  function automatic void add(logic r, logic ld, logic sl, logic [1:0] md, logic [31:0] d,
                              logic [3:0] a, logic oe, logic [31:0] ed, logic [3:0] ea);
    vec_t v;
    v.r = r; v.ld = ld; v.sl = sl; v.md = md; v.d = d; v.a = a; v.oe = oe; v.ed = ed; v.ea = ea;
    vecs.push_back(v);
  endfunction
  function automatic void idle(int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic void slot(logic [31:0] d, logic [3:0] a, logic oe = 0,
                               logic [31:0] ed = 0, logic [3:0] ea = 0);
    add(0, 1, 0, 0, d, a, oe, ed, ea);
  endfunction
  function automatic void selw(logic [31:0] d, logic [1:0] md);
    add(0, 1, 1, md, d, 4'hF, 0, 0, 0);
  endfunction
  function automatic void oe(logic [31:0] ed, logic [3:0] ea);
    add(0, 0, 0, 0, 0, 0, 1, ed, ea);
  endfunction
  initial begin
    exp_t e;
    logic [1:0] m;
    rst = 1'b0;
    bus.signal_load = 0; bus.signal_sel = 0; bus.signal_mode = 0;
    bus.data_in = 0; bus.attr_in = 0; bus.signal_oe = 0;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    for (int k = 3; k >= 0; k--) begin
      m = 2'(k);
      selw(32'h4000_0000, m);
      slot(32'hA1, 4'h1);
      slot(32'hA2, 4'h2);
      idle(2);
      slot(32'hA3, 4'h5);
      slot(32'hA4, 4'h4);
      idle(1);
      oe(m[1] ? 32'hA3 : 32'h0, m[0] ? 4'h5 : 4'h0);
      idle(1);
    end
    for (int k = 0; k < 5; k++) slot(32'hB0 + 32'(k), 4'(k));
    selw(32'h0, 2'd3);
    oe(32'hB4, 4'h4);
    oe(32'hB4, 4'h4);
    slot(32'hC0, 4'hC);
    selw(32'h0, 2'd3);
    oe(32'hC0, 4'hC);
    add(0, 0, 0, 2'd0, 32'h1234, 4'h3, 0, 0, 0);
    oe(32'hC0, 4'hC);
    slot(32'hC7, 4'h7, 1, 32'hC0, 4'hC);
    oe(32'hC7, 4'h7);
    slot(32'hC8, 4'h8);
    oe(32'hC8, 4'h8);
    slot(32'hD1, 4'h1);
    slot(32'hD2, 4'h2);
    add(1, 1, 0, 0, 32'hDD, 4'h9, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    oe(0, 0);
    slot(32'hD0, 4'hD);
    selw(32'h0, 2'd3);
    oe(32'hD0, 4'hD);
    slot(32'hE1, 4'h1);
    slot(32'hE2, 4'h2);
    slot(32'hE3, 4'h3);
    slot(32'hE4, 4'h4);
    selw(32'hE000_0000, 2'd2);
    oe(32'hE4, 4'h0);
    selw(32'h9FFF_FFFF, 2'd1);
    oe(32'h0, 4'h1);
    idle(2);
    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].r;
      bus.signal_load = vecs[i].ld;
      bus.signal_sel = vecs[i].sl;
      bus.signal_mode = vecs[i].md;
      bus.data_in = vecs[i].d;
      bus.attr_in = vecs[i].a;
      bus.signal_oe = vecs[i].oe;
      e.d = vecs[i].ed;
      e.a = vecs[i].ea;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_chk++;
      if (bus.data_out !== e.d) begin
        n_fail++;
        $display("FAIL data_out vec %0d: got %h expected %h", i, bus.data_out, e.d);
      end
      n_chk++;
      if (bus.attr_out !== e.a) begin
        n_fail++;
        $display("FAIL attr_out vec %0d: got %h expected %h", i, bus.attr_out, e.a);
      end
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
